// File: rtl/logic_result_skid_32_pkg.sv
// rtl/logic_result_skid_32_pkg.sv - shared widths and entry record for the AND-result skid buffer
package logic_result_skid_32_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int TAG_W  = 4;

  localparam logic [1:0] COUNT_EMPTY = 2'd0;
  localparam logic [1:0] COUNT_FULL  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              zero;
    logic [TAG_W-1:0]  tag;
  } entry_t;

endpackage

// File: rtl/logic_result_skid_32_zero_detect.sv
// rtl/logic_result_skid_32_zero_detect.sv - wide NOR producing the zero flag for a result word
module zero_detect_32
  import logic_result_skid_32_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              zero
);

  assign zero = ~|data;

endmodule

// File: rtl/logic_result_skid_32.sv
// rtl/logic_result_skid_32.sv - two-entry skid buffer annotating AND results with zero flag and tag
module logic_result_skid_32
  import logic_result_skid_32_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_Y,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_Y,
  output logic              OUT_ZERO,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic [1:0]        COUNT
);

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rdy_q, rdy_d;

  logic   in_zero;
  logic   push;
  logic   pop;
  entry_t head;

  zero_detect_32 u_zero_detect (
    .data (IN_Y),
    .zero (in_zero)
  );

  // rdy_q holds IN_READY low through reset and releases it on the first edge after
  assign IN_READY  = rdy_q & (count_q != COUNT_FULL);
  assign OUT_VALID = (count_q != COUNT_EMPTY);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  always_comb begin
    entry_d = entry_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    tag_d   = tag_q;
    rdy_d   = 1'b1;

    if (push) begin
      entry_d[wptr_q] = '{y: IN_Y, zero: in_zero, tag: tag_q};
      wptr_d          = ~wptr_q;
      tag_d           = tag_q + 1'b1;
    end

    if (pop) begin
      rptr_d = ~rptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry_q <= '{default: '0};
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= COUNT_EMPTY;
      tag_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      tag_q   <= tag_d;
      rdy_q   <= rdy_d;
    end
  end

  // Head is a mux of registered entries, so nothing from IN_* reaches OUT_* in the same cycle
  assign head     = entry_q[rptr_q];
  assign OUT_Y    = head.y;
  assign OUT_ZERO = head.zero;
  assign OUT_TAG  = head.tag;
  assign COUNT    = count_q;

endmodule
